// File: rtl/small_mac_bank.sv
// small_mac_bank: LANES parallel multiply-accumulate lanes. Each operand beat
// multiplies a public coefficient by a small sign-magnitude secret using
// shift-add, and a two-stage pipeline folds the product into a per-lane
// modular accumulator. Results are offered with a valid/ready handshake.
module small_mac_bank #(
  parameter int LANES  = 4,
  parameter int COEF_W = 13,
  parameter int SMAX   = 5,
  parameter int STEPS  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*COEF_W-1:0]   a_in,
  input  logic [LANES*4-1:0]        s_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*COEF_W-1:0]   acc_out,
  output logic                      err
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    sub_r;
  logic                    v1;
  logic [COEF_W-1:0]       acc   [LANES];
  logic [COEF_W-1:0]       p_r   [LANES];
  logic                    eff_r [LANES];
  logic [COEF_W-1:0]       prod  [LANES];
  logic [LANES-1:0]        bad;

  assign in_ready = (state == RUN);

  // Shift-add product per lane; illegal magnitudes contribute zero
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      logic [COEF_W-1:0] a;
      logic [2:0]        mag;
      a       = a_in[i*COEF_W +: COEF_W];
      mag     = s_in[i*4 +: 3];
      bad[i]  = (mag > 3'(SMAX));
      prod[i] = '0;
      if (mag[0]) prod[i] = prod[i] + a;
      if (mag[1]) prod[i] = prod[i] + {a[COEF_W-2:0], 1'b0};
      if (mag[2]) prod[i] = prod[i] + {a[COEF_W-3:0], 2'b00};
      if (bad[i]) prod[i] = '0;
    end
  end

  // Flatten accumulator registers onto the output bus
  always_comb begin
    acc_out = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_out[i*COEF_W +: COEF_W] = acc[i];
    end
  end

  // Control FSM, stage-1 product registers and stage-2 accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sub_r     <= 1'b0;
      v1        <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc[i]   <= '0;
        p_r[i]   <= '0;
        eff_r[i] <= 1'b0;
      end
    end else begin
      // Stage 2 sits before the FSM so a start-edge clear takes precedence;
      // v1 is always low in IDLE, so no pending product is lost.
      if (v1) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          acc[i] <= eff_r[i] ? acc[i] - p_r[i] : acc[i] + p_r[i];
        end
      end
      case (state)
        IDLE: begin
          v1 <= 1'b0;
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            err   <= 1'b0;
            sub_r <= sub;
            for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            v1  <= 1'b1;
            err <= err | (|bad);
            for (int unsigned i = 0; i < LANES; i++) begin
              p_r[i]   <= prod[i];
              eff_r[i] <= s_in[i*4+3] ^ sub_r;
            end
            if (cnt == LAST) state <= DRAIN;
            else             cnt   <= cnt + 1'b1;
          end else begin
            v1 <= 1'b0;
          end
        end
        DRAIN: begin
          v1        <= 1'b0;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          v1 <= 1'b0;
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
